// File: rtl/sbox_scheduler.sv
// rtl/sbox_scheduler.sv - time-shares four registered AES S-box lanes between state and key-word jobs
// Optional build macro: SBOX_SCHED_KEY_PRIO_EN (fixed key-over-state priority instead of round-robin).

// sub_box: one AES S-box lane, 1-cycle registered latency
module sub_box (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] addr_i,
   output logic [7:0] data_o
);

   logic [7:0] data_q;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254; zero maps to zero without special casing
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x126, x252;
      x2   = gf_mul(x, x);
      x3   = gf_mul(x2, x);
      x6   = gf_mul(x3, x3);
      x12  = gf_mul(x6, x6);
      x15  = gf_mul(x12, x3);
      x30  = gf_mul(x15, x15);
      x60  = gf_mul(x30, x30);
      x120 = gf_mul(x60, x60);
      x126 = gf_mul(x120, x6);
      x252 = gf_mul(x126, x126);
      return gf_mul(x252, x2);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   // Lane output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_q <= 8'h00;
      else        data_q <= sbox(addr_i);
   end

   assign data_o = data_q;

endmodule

// sbox_scheduler: issue FSM, arbitration, tag pipeline and result reassembly
module sbox_scheduler (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         st_valid,
   output logic         st_ready,
   input  logic [127:0] st_data,
   output logic         st_out_valid,
   input  logic         st_out_ready,
   output logic [127:0] st_out_data,
   input  logic         kw_valid,
   output logic         kw_ready,
   input  logic [31:0]  kw_data,
   output logic         kw_out_valid,
   input  logic         kw_out_ready,
   output logic [31:0]  kw_out_data,
   output logic         busy
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ST = 2'd1, S_KW = 2'd2} state_e;

   state_e       state_q, state_d;
   logic [1:0]   pass_q, pass_d;
   logic [127:0] st_word_q;
   logic [31:0]  kw_word_q;
   logic         st_inflight_q, kw_inflight_q;
   logic         st_out_valid_q, kw_out_valid_q;
   logic [127:0] st_out_data_q;
   logic [31:0]  kw_out_data_q;
   logic         s1_vld_q, s1_is_st_q;
   logic [1:0]   s1_pass_q;

   logic         slot_free, st_elig, kw_elig, st_grant, kw_grant, st_acc, kw_acc;
   logic         issue_vld, issue_is_st;
   logic [31:0]  issue_word, lane_out;

   // A new job may start whenever the cycle being issued is the last pass of the current job
   assign slot_free = (state_q == S_IDLE) || (state_q == S_KW) ||
                      ((state_q == S_ST) && (pass_q == 2'd3));
   assign st_elig = st_valid & slot_free & ~st_inflight_q & ~st_out_valid_q;
   assign kw_elig = kw_valid & slot_free & ~kw_inflight_q & ~kw_out_valid_q;

`ifdef SBOX_SCHED_KEY_PRIO_EN
   assign kw_grant = kw_elig;
   assign st_grant = st_elig & ~kw_elig;
`else
   logic prefer_st_q;

   // Round-robin pointer: remember who was granted last so the other wins the next tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      prefer_st_q <= 1'b1;
      else if (st_acc) prefer_st_q <= 1'b0;
      else if (kw_acc) prefer_st_q <= 1'b1;
   end

   assign st_grant = st_elig & (~kw_elig | prefer_st_q);
   assign kw_grant = kw_elig & (~st_elig | ~prefer_st_q);
`endif

   // Readies are forced low while reset is asserted so every output reads 0 during reset
   assign st_ready = rst_n & st_grant;
   assign kw_ready = rst_n & kw_grant;
   assign st_acc   = st_valid & st_ready;
   assign kw_acc   = kw_valid & kw_ready;

   // Issue FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pass_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         pass_q  <= pass_d;
      end
   end

   // Issue FSM next state: step through passes, or launch the accepted job with no bubble
   always_comb begin
      state_d = state_q;
      pass_d  = pass_q;
      if (slot_free) begin
         pass_d = 2'd0;
         if (st_acc)      state_d = S_ST;
         else if (kw_acc) state_d = S_KW;
         else             state_d = S_IDLE;
      end else begin
         pass_d = pass_q + 2'd1;
      end
   end

   // Issue FSM outputs: the 32-bit column driven to the lanes this cycle
   always_comb begin
      issue_vld   = (state_q != S_IDLE);
      issue_is_st = (state_q == S_ST);
      issue_word  = 32'h0;
      if (state_q == S_ST) begin
         case (pass_q)
            2'd0:    issue_word = st_word_q[127:96];
            2'd1:    issue_word = st_word_q[95:64];
            2'd2:    issue_word = st_word_q[63:32];
            default: issue_word = st_word_q[31:0];
         endcase
      end else if (state_q == S_KW) begin
         issue_word = kw_word_q;
      end
   end

   // Job words are latched on accept and held for the whole job
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_word_q <= 128'h0;
         kw_word_q <= 32'h0;
      end else begin
         if (st_acc) st_word_q <= st_data;
         if (kw_acc) kw_word_q <= kw_data;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         sub_box u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .addr_i(issue_word[8*gi +: 8]),
            .data_o(lane_out[8*gi +: 8])
         );
      end
   endgenerate

   // Capture tags travel alongside the lane register stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q   <= 1'b0;
         s1_is_st_q <= 1'b0;
         s1_pass_q  <= 2'd0;
      end else begin
         s1_vld_q   <= issue_vld;
         s1_is_st_q <= issue_is_st;
         s1_pass_q  <= pass_q;
      end
   end

   // Result capture, in-flight tracking and output handshakes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_out_data_q  <= 128'h0;
         kw_out_data_q  <= 32'h0;
         st_out_valid_q <= 1'b0;
         kw_out_valid_q <= 1'b0;
         st_inflight_q  <= 1'b0;
         kw_inflight_q  <= 1'b0;
      end else begin
         if (st_out_valid_q && st_out_ready) st_out_valid_q <= 1'b0;
         if (kw_out_valid_q && kw_out_ready) kw_out_valid_q <= 1'b0;
         if (st_acc) st_inflight_q <= 1'b1;
         if (kw_acc) kw_inflight_q <= 1'b1;
         if (s1_vld_q && s1_is_st_q) begin
            case (s1_pass_q)
               2'd0:    st_out_data_q[127:96] <= lane_out;
               2'd1:    st_out_data_q[95:64]  <= lane_out;
               2'd2:    st_out_data_q[63:32]  <= lane_out;
               default: st_out_data_q[31:0]   <= lane_out;
            endcase
            if (s1_pass_q == 2'd3) begin
               st_out_valid_q <= 1'b1;
               st_inflight_q  <= 1'b0;
            end
         end
         if (s1_vld_q && !s1_is_st_q) begin
            kw_out_data_q  <= lane_out;
            kw_out_valid_q <= 1'b1;
            kw_inflight_q  <= 1'b0;
         end
      end
   end

   assign st_out_valid = st_out_valid_q;
   assign kw_out_valid = kw_out_valid_q;
   assign st_out_data  = st_out_data_q;
   assign kw_out_data  = kw_out_data_q;
   assign busy         = issue_vld | s1_vld_q;

endmodule

// File: tb/tb_sbox_scheduler.sv
// tb/tb_sbox_scheduler.sv - randomized and directed self-checking bench for sbox_scheduler
module tb_sbox_scheduler;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         st_valid, st_ready, st_out_valid, st_out_ready;
   logic [127:0] st_data, st_out_data;
   logic         kw_valid, kw_ready, kw_out_valid, kw_out_ready;
   logic [31:0]  kw_data, kw_out_data;
   logic         busy;

   sbox_scheduler dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .st_valid    (st_valid),
      .st_ready    (st_ready),
      .st_data     (st_data),
      .st_out_valid(st_out_valid),
      .st_out_ready(st_out_ready),
      .st_out_data (st_out_data),
      .kw_valid    (kw_valid),
      .kw_ready    (kw_ready),
      .kw_data     (kw_data),
      .kw_out_valid(kw_out_valid),
      .kw_out_ready(kw_out_ready),
      .kw_out_data (kw_out_data),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // Reference S-box table built with the generator / log-walk method
   logic [7:0] tab [256];

   // Job-level model: c counts cycles, each job recorded by the cycle its output becomes valid
   int         c = 0;
   int         free_c, st_vc, kw_vc, busy_end;
   bit         st_act, kw_act, prefer_st;
   logic [127:0] st_exp;
   logic [31:0]  kw_exp;

   // Samples from the latest step, used by directed literal checks
   logic         s_st_rdy, s_kw_rdy, s_st_ov, s_kw_ov, s_busy;
   logic [127:0] s_st_d;
   logic [31:0]  s_kw_d;

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, c);
   endtask

   function automatic logic [7:0] rotl(input logic [7:0] v, input int s);
      logic [15:0] w;
      w = {v, v} << s;
      return w[15:8];
   endfunction

   task automatic build_tab();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if (q[7]) q = q ^ 8'h09;
         x = q ^ rotl(q, 1) ^ rotl(q, 2) ^ rotl(q, 3) ^ rotl(q, 4);
         tab[p] = x ^ 8'h63;
      end while (p != 8'h01);
      tab[0] = 8'h63;
   endtask

   function automatic logic [127:0] sub128(input logic [127:0] d);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = tab[d[8*i +: 8]];
      return r;
   endfunction

   function automatic logic [31:0] sub32(input logic [31:0] d);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = tab[d[8*i +: 8]];
      return r;
   endfunction

   task automatic model_reset();
      free_c = 0; st_act = 0; kw_act = 0; prefer_st = 1;
      st_vc = 0; kw_vc = 0; busy_end = 0;
   endtask

   // One cycle: drive inputs, compare every output against the model, then advance across the edge
   task automatic step(input bit sv, input logic [127:0] sd, input bit sor,
                       input bit kv, input logic [31:0] kd, input bit kor);
      bit st_el, kw_el, m_st_rdy, m_kw_rdy, m_st_ov, m_kw_ov, m_busy;
      int a;
      st_valid = sv; st_data = sd; st_out_ready = sor;
      kw_valid = kv; kw_data = kd; kw_out_ready = kor;
      #1;
      st_el = sv && (c >= free_c) && !st_act;
      kw_el = kv && (c >= free_c) && !kw_act;
`ifdef SBOX_SCHED_KEY_PRIO_EN
      m_kw_rdy = kw_el;
      m_st_rdy = st_el && !kw_el;
`else
      m_st_rdy = st_el && (!kw_el || prefer_st);
      m_kw_rdy = kw_el && (!st_el || !prefer_st);
`endif
      m_st_ov = st_act && (c >= st_vc);
      m_kw_ov = kw_act && (c >= kw_vc);
      m_busy  = (c < busy_end);
      s_st_rdy = st_ready; s_kw_rdy = kw_ready; s_st_ov = st_out_valid;
      s_kw_ov = kw_out_valid; s_busy = busy; s_st_d = st_out_data; s_kw_d = kw_out_data;
      chk("st_ready", st_ready, m_st_rdy);
      chk("kw_ready", kw_ready, m_kw_rdy);
      chk("st_out_valid", st_out_valid, m_st_ov);
      chk("kw_out_valid", kw_out_valid, m_kw_ov);
      chk("busy", busy, m_busy);
      if (m_st_ov) chk("st_out_data", st_out_data, st_exp);
      if (m_kw_ov) chk("kw_out_data", kw_out_data, kw_exp);
      @(posedge clk);
      a = c + 1;
      if (m_st_ov && sor) st_act = 0;
      if (m_kw_ov && kor) kw_act = 0;
      if (sv && m_st_rdy) begin
         st_act = 1; st_vc = a + 5; free_c = a + 3; st_exp = sub128(sd); prefer_st = 0;
         if (a + 5 > busy_end) busy_end = a + 5;
      end
      if (kv && m_kw_rdy) begin
         kw_act = 1; kw_vc = a + 2; free_c = a; kw_exp = sub32(kd); prefer_st = 1;
         if (a + 2 > busy_end) busy_end = a + 2;
      end
      c++;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, '0, 1, 0, '0, 1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_st_ready"}, st_ready, 0);
      chk({tag, "_kw_ready"}, kw_ready, 0);
      chk({tag, "_st_out_valid"}, st_out_valid, 0);
      chk({tag, "_kw_out_valid"}, kw_out_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_st_out_data"}, st_out_data, 0);
      chk({tag, "_kw_out_data"}, kw_out_data, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      st_valid = 1; kw_valid = 1; st_out_ready = 0; kw_out_ready = 0;
      st_data = '1; kw_data = '1;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("rst");
      rst_n = 1'b1;
      model_reset();
      c++;
   endtask

   logic [127:0] bp_a, bp_b;

   initial begin
      build_tab();
      model_reset();
      chk("tab_00", tab[8'h00], 8'h63);
      chk("tab_53", tab[8'h53], 8'hed);
      chk("tab_ff", tab[8'hff], 8'h16);
      chk("tab_01", tab[8'h01], 8'h7c);

      // Power-on reset with both valids high
      do_reset();

      // Key word alone
      step(0, '0, 1, 1, 32'h0053ff01, 1);
      chk("kw_alone_ready", s_kw_rdy, 1);
      step(0, '0, 1, 0, '0, 1);
      step(0, '0, 1, 0, '0, 1);
      step(0, '0, 1, 0, '0, 1);
      chk("kw_alone_valid", s_kw_ov, 1);
      chk("kw_alone_data", s_kw_d, 32'h63ed167c);
      step(0, '0, 1, 0, '0, 1);
      chk("kw_alone_cleared", s_kw_ov, 0);
      idle(2);

      // State alone
      step(1, 128'h000102030405060708090a0b0c0d0e0f, 1, 0, '0, 1);
      chk("st_alone_ready", s_st_rdy, 1);
      for (int i = 0; i < 5; i++) step(0, '0, 1, 0, '0, 1);
      chk("st_alone_not_early", s_st_ov, 0);
      step(0, '0, 1, 0, '0, 1);
      chk("st_alone_valid", s_st_ov, 1);
      chk("st_alone_data", s_st_d, 128'h637c777bf26b6fc53001672bfed7ab76);
      idle(2);

      // Simultaneous requests straight after reset
      do_reset();
      step(1, {4{$urandom}}, 1, 1, 32'h01020304, 1);
`ifdef SBOX_SCHED_KEY_PRIO_EN
      chk("tie_kw_first", s_kw_rdy, 1);
      chk("tie_st_waits", s_st_rdy, 0);
      step(1, 128'h00112233445566778899aabbccddeeff, 1, 0, '0, 1);
      chk("tie_st_second", s_st_rdy, 1);
      idle(8);
`else
      chk("tie_st_first", s_st_rdy, 1);
      chk("tie_kw_waits", s_kw_rdy, 0);
      for (int i = 1; i < 4; i++) begin
         step(0, '0, 1, 1, 32'h01020304, 1);
         chk("tie_kw_blocked", s_kw_rdy, 0);
      end
      step(0, '0, 1, 1, 32'h01020304, 1);
      chk("tie_kw_b2b", s_kw_rdy, 1);
      step(0, '0, 1, 0, '0, 1);
      step(0, '0, 1, 0, '0, 1);
      chk("tie_kw_not_early", s_kw_ov, 0);
      step(0, '0, 1, 0, '0, 1);
      chk("tie_kw_valid", s_kw_ov, 1);
      chk("tie_kw_data", s_kw_d, 32'h7c777bf2);
      idle(4);
`endif

      // Backpressure on the state output
      bp_a = {$urandom, $urandom, $urandom, $urandom};
      bp_b = {$urandom, $urandom, $urandom, $urandom};
      step(1, bp_a, 0, 0, '0, 1);
      for (int i = 0; i < 5; i++) step(1, bp_b, 0, 0, '0, 1);
      for (int i = 0; i < 10; i++) begin
         step(1, bp_b, 0, 0, '0, 1);
         chk("bp_ready_low", s_st_rdy, 0);
         chk("bp_data_stable", s_st_d, sub128(bp_a));
      end
      step(1, bp_b, 1, 0, '0, 1);
      chk("bp_handshake_ready_low", s_st_rdy, 0);
      step(1, bp_b, 1, 0, '0, 1);
      chk("bp_next_accept", s_st_rdy, 1);
      idle(8);

      // Reset between E2 and E3 of a state job
      step(1, {4{$urandom}}, 1, 0, '0, 1);
      step(0, '0, 1, 0, '0, 1);
      step(0, '0, 1, 0, '0, 1);
      st_valid = 1; kw_valid = 1;
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      model_reset();
      c++;
      idle(8);
      step(0, '0, 1, 1, 32'hdeadbeef, 1);
      chk("midrst_kw_accept", s_kw_rdy, 1);
      idle(3);
      chk("midrst_kw_valid", s_kw_ov, 1);
      chk("midrst_kw_data", s_kw_d, 32'h1d95aedf);
      idle(2);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         step(($urandom % 3) != 0, {$urandom, $urandom, $urandom, $urandom}, ($urandom % 4) != 0,
              ($urandom % 3) != 0, $urandom, ($urandom % 4) != 0);
      end
      idle(10);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
